// File: rtl/weight_bank_loader_pkg.sv
// Shared definitions for the weight shadow-memory writer, shadow memory and A-SPSA engine.
// Error codes, FSM encodings and default bank geometry live here so all users agree.
package weight_bank_loader_pkg;
  localparam int DEF_WEIGHT_WIDTH  = 16;
  localparam int DEF_ADDR_WIDTH    = 16;
  localparam int DEF_TOTAL_WEIGHTS = 1298;
  localparam int DEF_NUM_BANKS     = 3;
  localparam int DEF_SWAP_TIMEOUT  = 4096;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_LENGTH   = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_BAD_BANK = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_DRAIN, ST_REQ, ST_REL, ST_FIN
  } wbl_state_e;

  typedef enum logic [1:0] {
    HS_IDLE, HS_REQ, HS_REL
  } hs_state_e;
endpackage

// File: rtl/weight_bank_loader_if.sv
// AXI-Stream weight input: one Q1.15 word per beat, last marks the final word of a bank.
interface weight_bank_loader_if #(
  parameter int WEIGHT_WIDTH = 16
) ();
  logic [WEIGHT_WIDTH-1:0] s_axis_w_data;
  logic                    s_axis_w_valid;
  logic                    s_axis_w_last;
  logic                    s_axis_w_ready;

  modport master (output s_axis_w_data, s_axis_w_valid, s_axis_w_last, input s_axis_w_ready);
  modport slave  (input s_axis_w_data, s_axis_w_valid, s_axis_w_last, output s_axis_w_ready);
endinterface

// File: rtl/weight_bank_loader_swap.sv
// Four-phase commit initiator: raise req, wait ack high, drop req, wait ack low,
// with a per-edge timeout. Shared with the A-SPSA engine.
module swap_handshake_initiator
  import weight_bank_loader_pkg::*;
#(
  parameter int SWAP_TIMEOUT = DEF_SWAP_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic swap_ack,
  output logic swap_req,
  output logic complete,
  output logic timeout
);
  localparam int CW = $clog2(SWAP_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SWAP_TIMEOUT - 1);

  hs_state_e   st;
  logic [CW-1:0] cnt;
  logic        waiting;

  // An ack edge arriving in the final counted cycle wins over the timeout.
  assign waiting  = (st == HS_REQ && !swap_ack) || (st == HS_REL && swap_ack);
  assign timeout  = waiting && (cnt == CNT_LAST);
  assign complete = (st == HS_REL) && !swap_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= HS_IDLE;
      swap_req <= 1'b0;
      cnt      <= '0;
    end else begin
      case (st)
        HS_IDLE: if (go) begin
          st       <= HS_REQ;
          swap_req <= 1'b1;
          cnt      <= '0;
        end
        HS_REQ: if (swap_ack) begin
          st       <= HS_REL;
          swap_req <= 1'b0;
          cnt      <= '0;
        end else if (timeout) begin
          st       <= HS_IDLE;
          swap_req <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        HS_REL: if (!swap_ack || timeout) st <= HS_IDLE;
                else cnt <= cnt + 1'b1;
        default: st <= HS_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/weight_bank_loader.sv
// Streams one weight bank into the shadow memory, then commits it via the swap handshake.
// Length or bank errors abort without a swap; done pulses at the end of every load.
module weight_bank_loader
  import weight_bank_loader_pkg::*;
#(
  parameter int WEIGHT_WIDTH  = DEF_WEIGHT_WIDTH,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int TOTAL_WEIGHTS = DEF_TOTAL_WEIGHTS,
  parameter int NUM_BANKS     = DEF_NUM_BANKS,
  parameter int SWAP_TIMEOUT  = DEF_SWAP_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              bank_sel_in,
  weight_bank_loader_if.slave     s_axis,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [WEIGHT_WIDTH-1:0] wr_data,
  output logic                    wr_en,
  output logic [1:0]              wr_bank_sel,
  output logic                    swap_req,
  input  logic                    swap_ack,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              err_code,
  output logic [ADDR_WIDTH-1:0]   word_count
);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(TOTAL_WEIGHTS - 1);

  wbl_state_e state;
  logic       beat, at_last_idx, hs_go, hs_complete, hs_timeout;

  assign beat        = s_axis.s_axis_w_valid && s_axis.s_axis_w_ready;
  assign at_last_idx = (word_count == LAST_IDX);
  assign hs_go       = (state == ST_LOAD) && beat && at_last_idx && s_axis.s_axis_w_last;

  swap_handshake_initiator #(.SWAP_TIMEOUT(SWAP_TIMEOUT)) u_swap (
    .clk      (clk),
    .rst      (rst),
    .go       (hs_go),
    .swap_ack (swap_ack),
    .swap_req (swap_req),
    .complete (hs_complete),
    .timeout  (hs_timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= ST_IDLE;
      s_axis.s_axis_w_ready <= 1'b0;
      wr_addr               <= '0;
      wr_data               <= '0;
      wr_en                 <= 1'b0;
      wr_bank_sel           <= '0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      err_code              <= ERR_OK;
      word_count            <= '0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          busy       <= 1'b1;
          word_count <= '0;
          if ({30'd0, bank_sel_in} < NUM_BANKS) begin
            state                 <= ST_LOAD;
            wr_bank_sel           <= bank_sel_in;
            err_code              <= ERR_OK;
            s_axis.s_axis_w_ready <= 1'b1;
          end else begin
            state    <= ST_FIN;
            err_code <= ERR_BAD_BANK;
            done     <= 1'b1;
          end
        end
        ST_LOAD: if (beat) begin
          wr_en      <= 1'b1;
          wr_data    <= s_axis.s_axis_w_data;
          wr_addr    <= word_count;
          word_count <= word_count + 1'b1;
          if (at_last_idx && s_axis.s_axis_w_last) begin
            state                 <= ST_REQ;
            s_axis.s_axis_w_ready <= 1'b0;
          end else if (at_last_idx) begin
            // Bank is full but the stream keeps going: swallow the rest.
            state    <= ST_DRAIN;
            err_code <= ERR_LENGTH;
          end else if (s_axis.s_axis_w_last) begin
            state                 <= ST_FIN;
            err_code              <= ERR_LENGTH;
            s_axis.s_axis_w_ready <= 1'b0;
            done                  <= 1'b1;
          end
        end
        ST_DRAIN: if (beat && s_axis.s_axis_w_last) begin
          state                 <= ST_FIN;
          s_axis.s_axis_w_ready <= 1'b0;
          done                  <= 1'b1;
        end
        ST_REQ: if (swap_ack) begin
          state <= ST_REL;
        end else if (hs_timeout) begin
          state    <= ST_FIN;
          err_code <= ERR_TIMEOUT;
          done     <= 1'b1;
        end
        ST_REL: if (hs_complete) begin
          state <= ST_FIN;
          done  <= 1'b1;
        end else if (hs_timeout) begin
          state    <= ST_FIN;
          err_code <= ERR_TIMEOUT;
          done     <= 1'b1;
        end
        ST_FIN: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_weight_bank_loader.sv
// Directed bench for weight_bank_loader with an 8-word bank and a 16-cycle swap timeout.
module tb_weight_bank_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  bank_sel_in = '0;
  logic [15:0] wr_addr, wr_data, word_count;
  logic        wr_en, swap_req, busy, done;
  logic        swap_ack = 1'b0;
  logic [1:0]  wr_bank_sel, err_code;

  int nchk = 0;
  int nerr = 0;

  // write/handshake monitor, written only here
  int          nwr = 0, nreq = 0, ndone = 0, req_nwr = 0;
  logic [15:0] wa [256];
  logic [15:0] wd [256];
  logic [1:0]  wbs [256];
  logic [1:0]  done_err = '0;
  logic [15:0] done_wc = '0;
  logic        req_prev = 1'b0;

  int b_wr, b_req, b_done;
  bit bad;

  weight_bank_loader_if #(.WEIGHT_WIDTH(16)) axis ();

  weight_bank_loader #(
    .WEIGHT_WIDTH(16), .ADDR_WIDTH(16), .TOTAL_WEIGHTS(8), .NUM_BANKS(3), .SWAP_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bank_sel_in(bank_sel_in), .s_axis(axis.slave),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .wr_bank_sel(wr_bank_sel),
    .swap_req(swap_req), .swap_ack(swap_ack), .busy(busy), .done(done),
    .err_code(err_code), .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en && nwr < 256) begin
      wa[nwr] = wr_addr; wd[nwr] = wr_data; wbs[nwr] = wr_bank_sel;
      nwr++;
    end
    if (swap_req) nreq++;
    if (swap_req && !req_prev) req_nwr = nwr;
    req_prev = swap_req;
    if (done) begin
      ndone++; done_err = err_code; done_wc = word_count;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [1:0] b);
    start = 1'b1; bank_sel_in = b;
    step();
    start = 1'b0;
  endtask

  // leaves valid high so back-to-back calls stream one beat per cycle
  task automatic drive_beat(input logic [15:0] d, input logic l);
    bit acc = 1'b0;
    axis.s_axis_w_valid = 1'b1; axis.s_axis_w_data = d; axis.s_axis_w_last = l;
    for (int k = 0; k < 50; k++) begin
      if (axis.s_axis_w_ready) begin acc = 1'b1; step(); break; end
      step();
    end
    if (!acc) chk("beat_accept", 32'(acc), 32'd1);
  endtask

  task automatic send_bank(input logic [15:0] base, input int n, input int last_at);
    for (int i = 0; i < n; i++) drive_beat(base + 16'(i), i == last_at);
    axis.s_axis_w_valid = 1'b0; axis.s_axis_w_last = 1'b0;
  endtask

  task automatic do_ack(input int dly);
    for (int k = 0; k < 50 && !swap_req; k++) step();
    chk("req_rise", 32'(swap_req), 32'd1);
    for (int k = 0; k < dly; k++) step();
    swap_ack = 1'b1;
    for (int k = 0; k < 50 && swap_req; k++) step();
    chk("req_fall", 32'(swap_req), 32'd0);
    swap_ack = 1'b0;
  endtask

  task automatic wait_done(input int base, input string tag);
    for (int k = 0; k < 200 && ndone == base; k++) step();
    chk(tag, 32'(ndone - base), 32'd1);
    step();
  endtask

  task automatic chk_writes(input string tag, input int base, input int n,
                            input logic [15:0] dbase, input logic [1:0] bank);
    bit b = 1'b0;
    chk({tag, "_count"}, 32'(nwr - base), 32'(n));
    for (int i = 0; i < n; i++)
      if (wa[base+i] !== 16'(i) || wd[base+i] !== dbase + 16'(i) || wbs[base+i] !== bank) b = 1'b1;
    chk({tag, "_content"}, 32'(b), 32'd0);
  endtask

  initial begin
    axis.s_axis_w_valid = 1'b0; axis.s_axis_w_data = '0; axis.s_axis_w_last = 1'b0;
    step(); step(); step();
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_ready", 32'(axis.s_axis_w_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_swap_req", 32'(swap_req), 0);
    chk("rst_outs", {wr_addr, wr_data}, 0);
    chk("rst_misc", {14'd0, wr_bank_sel, err_code, done, 11'd0}, 0);
    chk("rst_word_count", 32'(word_count), 0);
    rst = 1'b0;
    step();

    // 1: good load into bank 1, ack after 3 cycles
    b_wr = nwr; b_done = ndone;
    do_start(2'd1);
    chk("s1_busy", 32'(busy), 1);
    chk("s1_ready", 32'(axis.s_axis_w_ready), 1);
    send_bank(16'h0100, 8, 7);
    do_ack(3);
    wait_done(b_done, "s1_done");
    chk("s1_req_after_8th_write", 32'(req_nwr - b_wr), 8);
    chk_writes("s1_wr", b_wr, 8, 16'h0100, 2'd1);
    chk("s1_err", 32'(done_err), 0);
    chk("s1_wc", 32'(done_wc), 8);
    chk("s1_idle_busy", 32'(busy), 0);

    // 2: early last on beat 5
    b_wr = nwr; b_req = nreq; b_done = ndone;
    do_start(2'd0);
    send_bank(16'h0200, 5, 4);
    wait_done(b_done, "s2_done");
    chk_writes("s2_wr", b_wr, 5, 16'h0200, 2'd0);
    chk("s2_no_swap", 32'(nreq - b_req), 0);
    chk("s2_err", 32'(done_err), 1);
    chk("s2_wc", 32'(done_wc), 5);

    // 3: 11 beats, last only on the 11th
    b_wr = nwr; b_req = nreq; b_done = ndone;
    do_start(2'd2);
    send_bank(16'h0300, 11, 10);
    wait_done(b_done, "s3_done");
    chk_writes("s3_wr", b_wr, 8, 16'h0300, 2'd2);
    chk("s3_no_swap", 32'(nreq - b_req), 0);
    chk("s3_err", 32'(done_err), 1);
    chk("s3_wc", 32'(done_wc), 8);

    // 4: ack never returns -> timeout, then a clean load clears err_code
    b_wr = nwr; b_req = nreq; b_done = ndone;
    do_start(2'd0);
    chk("s4_err_cleared_on_start", 32'(err_code), 0);
    send_bank(16'h0400, 8, 7);
    wait_done(b_done, "s4_done");
    chk("s4_req_cycles", 32'(nreq - b_req), 16);
    chk("s4_err", 32'(done_err), 2);
    chk("s4_req_low", 32'(swap_req), 0);
    b_wr = nwr; b_done = ndone;
    do_start(2'd1);
    send_bank(16'h0500, 8, 7);
    do_ack(0);
    wait_done(b_done, "s4b_done");
    chk_writes("s4b_wr", b_wr, 8, 16'h0500, 2'd1);
    chk("s4b_err", 32'(done_err), 0);

    // 5: bad bank, with a beat waiting in IDLE
    b_wr = nwr; b_req = nreq;
    axis.s_axis_w_valid = 1'b1; axis.s_axis_w_data = 16'hdead; axis.s_axis_w_last = 1'b0;
    do_start(2'd3);
    chk("s5_done_pulse", 32'(done), 1);
    chk("s5_err", 32'(err_code), 3);
    chk("s5_ready", 32'(axis.s_axis_w_ready), 0);
    step();
    chk("s5_done_one_cycle", 32'(done), 0);
    chk("s5_busy", 32'(busy), 0);
    chk("s5_no_writes", 32'(nwr - b_wr), 0);
    chk("s5_no_swap", 32'(nreq - b_req), 0);
    axis.s_axis_w_valid = 1'b0;
    step();

    // 6: gappy valid, ignored start, reset at beat 4
    b_wr = nwr; b_req = nreq;
    do_start(2'd1);
    drive_beat(16'h0600, 1'b0); axis.s_axis_w_valid = 1'b0; step();
    drive_beat(16'h0601, 1'b0); axis.s_axis_w_valid = 1'b0;
    start = 1'b1; bank_sel_in = 2'd2; step(); start = 1'b0;
    chk("s6_bank_kept", 32'(wr_bank_sel), 1);
    chk("s6_err_kept", 32'(err_code), 0);
    chk("s6_wc_mid", 32'(word_count), 2);
    drive_beat(16'h0602, 1'b0);
    axis.s_axis_w_data = 16'h0603; rst = 1'b1;
    step();
    chk("s6_rst_outs", {wr_addr, wr_data}, 0);
    chk("s6_rst_misc", {22'd0, wr_en, axis.s_axis_w_ready, busy, done, swap_req, wr_bank_sel, err_code}, 0);
    chk("s6_rst_wc", 32'(word_count), 0);
    rst = 1'b0; axis.s_axis_w_valid = 1'b0;
    step(); step(); step();
    chk_writes("s6_wr", b_wr, 3, 16'h0600, 2'd1);
    chk("s6_no_swap", 32'(nreq - b_req), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
